wb_regfile_sb: RTL and testbench
================================

// Module: wb_regfile_sb
// PURPOSE
// Integer register file plus write-back scoreboard: the receiving end of the WB stage's rd_idx/rd_data.
// Retires WB writes into 32 x XLEN registers, serves two combinational read ports to ID with same-cycle
// WB bypass, and tracks per-register in-flight writes so ID can stall on read-after-write hazards.
// PARAMETERS
// XLEN    64  register width
// CNT_W   2   width of per-register in-flight counter (max 2**CNT_W-1 outstanding writes per rd)
// PORTS
// clk             in   1     core clock, all state updates on posedge
// rst_n           in   1     asynchronous active-low reset
// wb_wren_i       in   1     WB stage retires an instruction that writes rd
// wb_rd_idx_i     in   5     WB destination index
// wb_rd_data_i    in   XLEN  WB write data
// rs1_idx_i       in   5     ID read port 1 index
// rs2_idx_i       in   5     ID read port 2 index
// rs1_data_o      out  XLEN  read data port 1 (combinational)
// rs2_data_o      out  XLEN  read data port 2 (combinational)
// issue_valid_i   in   1     ID issues an instruction this cycle (only when issue_ready_o=1)
// issue_wren_i    in   1     issued instruction writes rd
// issue_rd_idx_i  in   5     issued instruction's rd
// rs1_used_i      in   1     issuing instruction reads rs1
// rs2_used_i      in   1     issuing instruction reads rs2
// squash_valid_i  in   1     one in-flight writer squashed (branch/trap flush), one per cycle
// squash_rd_idx_i in   5     rd of squashed writer
// issue_ready_o   out  1     0 = ID must stall (RAW hazard or counter full)
// busy_vec_o      out  32    bit i = counter[i] != 0 (registered state)
// BEHAVIOUR
// - Reset (rst_n=0, async): all 32 registers = 0, all counters = 0; busy_vec_o=0, issue_ready_o=1.
// - x0: reads always 0; writes, issues, squashes to index 0 ignored (counter[0] stays 0).
// - Write: posedge with wb_wren_i && idx!=0 -> reg[idx] <= wb_rd_data_i. Latency 1 cycle to array.
// - Read: rsN_data_o = 0 if idx==0; else wb_rd_data_i if wb_wren_i && wb_rd_idx_i==idx (bypass);
//   else reg[idx]. Zero cycles, purely combinational.
// - Counters, per register r!=0, per posedge: next = cnt + inc - dec_wb - dec_sq where
//   inc=issue_valid_i&&issue_wren_i&&issue_rd_idx_i==r, dec_wb=wb_wren_i&&wb_rd_idx_i==r,
//   dec_sq=squash_valid_i&&squash_rd_idx_i==r. All three may coincide; net arithmetic applies.
// - Decrement below 0 is a protocol error: counter saturates at 0 (assertion in sim).
// - Hazard: a source r counts as pending if cnt[r]!=0 and not (cnt[r]==1 && dec_wb for r this cycle),
//   i.e. the last outstanding write retiring this cycle is covered by the bypass.
// - issue_ready_o = 0 if (rs1_used_i && rs1 pending) || (rs2_used_i && rs2 pending)
//   || (issue_wren_i && cnt[issue_rd_idx_i]==2**CNT_W-1 && no dec this cycle for that rd).
// - issue_valid_i while issue_ready_o=0 is ignored (no counter change); assertion in sim.
// - Reset mid-operation: all state cleared immediately; in-flight WB after reset release is not expected.
// TESTING
// 1 reset: rst_n low mid-run -> rs1_data_o=0 all idx, busy_vec_o=0, issue_ready_o=1 without clk edge.
// 2 write/read: WB x5=0xDEAD_BEEF; next cycle rs1_idx=5 -> 0xDEADBEEF; WB x0=0x1 -> read x0 = 0.
// 3 bypass: wb_wren=1 idx=7 data=0x42, same cycle rs2_idx=7 -> rs2_data_o=0x42 while reg[7] still old.
// 4 RAW stall: issue x3 writer; next cycle rs1_used, rs1=3 -> issue_ready_o=0; cycle WB retires x3 ->
//   issue_ready_o=1, rs1_data_o=WB data; busy_vec_o[3] 0 after that edge.
// 5 counter full: 3 issues to x9 (CNT_W=2) -> 4th writer to x9 stalled; same cycle WB x9 -> ready=1.
// 6 squash+issue+WB all on x4 with cnt=2 -> cnt=1; squash on cnt=0 -> stays 0, assertion fires.

Source files
------------

// File: rtl/wb_regfile_sb.sv
// Integer register file with two bypassed read ports and a per-register in-flight write scoreboard.
// Reads are zero-cycle, writes land one edge later; ID stalls (issue_ready_o=0) on RAW hazard or full counter.
module wb_regfile_sb #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_wren_i,
  input  logic [4:0]      wb_rd_idx_i,
  input  logic [XLEN-1:0] wb_rd_data_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic [4:0]      rs2_idx_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            issue_valid_i,
  input  logic            issue_wren_i,
  input  logic [4:0]      issue_rd_idx_i,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  input  logic            squash_valid_i,
  input  logic [4:0]      squash_rd_idx_i,
  output logic            issue_ready_o,
  output logic [31:0]     busy_vec_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [XLEN-1:0]  regs_q [32];
  logic [XLEN-1:0]  regs_d [32];
  logic [CNT_W-1:0] cnt_q  [32];
  logic [CNT_W-1:0] cnt_d  [32];

  logic [31:0] dec_wb;
  logic [31:0] dec_sq;
  logic [31:0] inc;
  logic [31:0] pending;
  logic [31:0] underflow;
  logic        issue_ready;
  logic        full_stall;
  logic        issue_fire;

  // x0 never matches any decode, so its counter can never move.
  always_comb begin
    dec_wb      = '0;
    dec_sq      = '0;
    inc         = '0;
    pending     = '0;
    full_stall  = 1'b0;
    issue_ready = 1'b1;
    issue_fire  = 1'b0;
    for (int r = 0; r < 32; r++) begin
      dec_wb[r]  = (r != 0) && wb_wren_i && (wb_rd_idx_i == 5'(r));
      dec_sq[r]  = (r != 0) && squash_valid_i && (squash_rd_idx_i == 5'(r));
      // The last outstanding write retiring this cycle is served by the bypass.
      pending[r] = (cnt_q[r] != '0) && !((cnt_q[r] == CNT_W'(1)) && dec_wb[r]);
    end
    full_stall  = issue_wren_i && (cnt_q[issue_rd_idx_i] == CNT_MAX)
                  && !dec_wb[issue_rd_idx_i] && !dec_sq[issue_rd_idx_i];
    issue_ready = !((rs1_used_i && pending[rs1_idx_i]) ||
                    (rs2_used_i && pending[rs2_idx_i]) ||
                    full_stall);
    issue_fire  = issue_valid_i && issue_ready;
    for (int r = 0; r < 32; r++) begin
      inc[r] = (r != 0) && issue_fire && issue_wren_i && (issue_rd_idx_i == 5'(r));
    end
  end

  always_comb begin
    logic [CNT_W:0] up;
    logic [CNT_W:0] down;
    logic [CNT_W:0] diff;
    up        = '0;
    down      = '0;
    diff      = '0;
    underflow = '0;
    for (int r = 0; r < 32; r++) begin
      up   = {1'b0, cnt_q[r]} + {{CNT_W{1'b0}}, inc[r]};
      down = {{CNT_W{1'b0}}, dec_wb[r]} + {{CNT_W{1'b0}}, dec_sq[r]};
      diff = up - down;
      underflow[r] = (up < down);
      // A spurious retire/squash clamps at zero rather than wrapping to "full".
      cnt_d[r] = underflow[r] ? '0 : diff[CNT_W-1:0];
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_wren_i && (wb_rd_idx_i != 5'd0)) begin
      regs_d[wb_rd_idx_i] = wb_rd_data_i;
    end
  end

  always_comb begin
    rs1_data_o = regs_q[rs1_idx_i];
    if (wb_wren_i && (wb_rd_idx_i == rs1_idx_i)) rs1_data_o = wb_rd_data_i;
    if (rs1_idx_i == 5'd0) rs1_data_o = '0;
    rs2_data_o = regs_q[rs2_idx_i];
    if (wb_wren_i && (wb_rd_idx_i == rs2_idx_i)) rs2_data_o = wb_rd_data_i;
    if (rs2_idx_i == 5'd0) rs2_data_o = '0;
  end

  always_comb begin
    busy_vec_o = '0;
    for (int r = 0; r < 32; r++) begin
      busy_vec_o[r] = (cnt_q[r] != '0);
    end
  end

  assign issue_ready_o = issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) underflow == '0)
    else $warning("wb_regfile_sb: retire/squash with no in-flight write, regs %h", underflow);

  a_issue_when_ready: assert property (@(posedge clk) disable iff (!rst_n)
                                       !(issue_valid_i && !issue_ready))
    else $error("wb_regfile_sb: issue_valid_i asserted while issue_ready_o low");

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Bench for wb_regfile_sb: directed scenarios plus random traffic against an array/counter reference model.
module tb_wb_regfile_sb;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wb_wren_i;
  logic [4:0]      wb_rd_idx_i;
  logic [XLEN-1:0] wb_rd_data_i;
  logic [4:0]      rs1_idx_i;
  logic [4:0]      rs2_idx_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic            issue_valid_i;
  logic            issue_wren_i;
  logic [4:0]      issue_rd_idx_i;
  logic            rs1_used_i;
  logic            rs2_used_i;
  logic            squash_valid_i;
  logic [4:0]      squash_rd_idx_i;
  logic            issue_ready_o;
  logic [31:0]     busy_vec_o;

  int vectors = 0;
  int miscompares = 0;

  logic [XLEN-1:0] m_regs [32];
  int              m_cnt  [32];

  always #5 clk = ~clk;

  wb_regfile_sb #(.XLEN(XLEN), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_wren_i(wb_wren_i), .wb_rd_idx_i(wb_rd_idx_i), .wb_rd_data_i(wb_rd_data_i),
    .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .issue_valid_i(issue_valid_i), .issue_wren_i(issue_wren_i), .issue_rd_idx_i(issue_rd_idx_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .squash_valid_i(squash_valid_i), .squash_rd_idx_i(squash_rd_idx_i),
    .issue_ready_o(issue_ready_o), .busy_vec_o(busy_vec_o)
  );

  function automatic logic [XLEN-1:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    if (wb_wren_i && wb_rd_idx_i == idx) return wb_rd_data_i;
    return m_regs[idx];
  endfunction

  function automatic bit m_pending(input logic [4:0] r);
    return (r != 5'd0) && (m_cnt[r] != 0) && !(m_cnt[r] == 1 && wb_wren_i && wb_rd_idx_i == r);
  endfunction

  function automatic bit m_ready();
    bit full;
    full = issue_wren_i && (issue_rd_idx_i != 5'd0) && (m_cnt[issue_rd_idx_i] == 3)
           && !(wb_wren_i && wb_rd_idx_i == issue_rd_idx_i)
           && !(squash_valid_i && squash_rd_idx_i == issue_rd_idx_i);
    return !((rs1_used_i && m_pending(rs1_idx_i)) || (rs2_used_i && m_pending(rs2_idx_i)) || full);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 0; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
  endtask

  task automatic idle();
    wb_wren_i = 0; wb_rd_idx_i = '0; wb_rd_data_i = '0;
    rs1_idx_i = '0; rs2_idx_i = '0; rs1_used_i = 0; rs2_used_i = 0;
    issue_valid_i = 0; issue_wren_i = 0; issue_rd_idx_i = '0;
    squash_valid_i = 0; squash_rd_idx_i = '0;
  endtask

  // Advance one clock: work out the reference next state from the current inputs, then commit at the edge.
  task automatic tick();
    int              nc [32];
    logic [XLEN-1:0] nr [32];
    bit              fire;
    int              n;
    fire = issue_valid_i && m_ready();
    for (int r = 0; r < 32; r++) begin
      nr[r] = m_regs[r];
      nc[r] = 0;
      if (r != 0) begin
        n = m_cnt[r]
            + ((fire && issue_wren_i && issue_rd_idx_i == 5'(r)) ? 1 : 0)
            - ((wb_wren_i && wb_rd_idx_i == 5'(r)) ? 1 : 0)
            - ((squash_valid_i && squash_rd_idx_i == 5'(r)) ? 1 : 0);
        nc[r] = (n < 0) ? 0 : n;
        if (wb_wren_i && wb_rd_idx_i == 5'(r)) nr[r] = wb_rd_data_i;
      end
    end
    @(posedge clk);
    for (int r = 0; r < 32; r++) begin
      m_cnt[r]  = nc[r];
      m_regs[r] = nr[r];
    end
    @(negedge clk);
  endtask

  task automatic issue_to(input logic [4:0] rd);
    idle(); issue_valid_i = 1; issue_wren_i = 1; issue_rd_idx_i = rd;
    tick();
  endtask

  task automatic test_reset(input bit midrun);
    if (midrun) begin
      issue_to(5'd6);
      #2; vectors++;
      if (busy_vec_o[6] !== 1'b1) begin
        miscompares++; $display("FAIL pre_reset_busy6 got %b want 1", busy_vec_o[6]);
      end
    end
    idle(); rs1_idx_i = 5'd5; rs2_idx_i = 5'd6;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (busy_vec_o !== 32'h0) begin
      miscompares++; $display("FAIL reset_busy got %h want %h", busy_vec_o, 32'h0);
    end
    vectors++;
    if (issue_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready got %b want 1", issue_ready_o);
    end
    vectors++;
    if (rs1_data_o !== '0) begin
      miscompares++; $display("FAIL reset_rs1_x5 got %h want 0", rs1_data_o);
    end
    for (int i = 0; i < 32; i++) begin
      rs1_idx_i = 5'(i); rs2_idx_i = 5'(31 - i);
      #1; vectors++;
      if (rs1_data_o !== '0 || rs2_data_o !== '0) begin
        miscompares++;
        $display("FAIL reset_read idx %0d got %h/%h want 0/0", i, rs1_data_o, rs2_data_o);
      end
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_write_read();
    issue_to(5'd5);
    idle(); wb_wren_i = 1; wb_rd_idx_i = 5'd5; wb_rd_data_i = 64'hDEAD_BEEF;
    tick();
    idle(); rs1_idx_i = 5'd5;
    #2; vectors++;
    if (rs1_data_o !== 64'hDEAD_BEEF) begin
      miscompares++; $display("FAIL wr_read_x5 got %h want %h", rs1_data_o, 64'hDEAD_BEEF);
    end
    vectors++;
    if (busy_vec_o[5] !== 1'b0) begin
      miscompares++; $display("FAIL wr_busy5 got %b want 0", busy_vec_o[5]);
    end
    idle(); wb_wren_i = 1; wb_rd_idx_i = 5'd0; wb_rd_data_i = 64'h1; rs1_idx_i = 5'd0;
    #2; vectors++;
    if (rs1_data_o !== '0) begin
      miscompares++; $display("FAIL x0_bypass got %h want 0", rs1_data_o);
    end
    tick();
    idle(); rs1_idx_i = 5'd0; rs2_idx_i = 5'd5;
    #2; vectors++;
    if (rs1_data_o !== '0 || rs2_data_o !== 64'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL x0_after_write got %h/%h want 0/%h", rs1_data_o, rs2_data_o, 64'hDEAD_BEEF);
    end
  endtask

  task automatic test_bypass();
    issue_to(5'd7);
    idle(); wb_wren_i = 1; wb_rd_idx_i = 5'd7; wb_rd_data_i = 64'h42; rs2_idx_i = 5'd7; rs1_idx_i = 5'd5;
    #2; vectors++;
    if (rs2_data_o !== 64'h42) begin
      miscompares++; $display("FAIL bypass_rs2 got %h want %h", rs2_data_o, 64'h42);
    end
    vectors++;
    if (rs1_data_o !== 64'hDEAD_BEEF) begin
      miscompares++; $display("FAIL bypass_other_port got %h want %h", rs1_data_o, 64'hDEAD_BEEF);
    end
    tick();
    idle(); rs1_idx_i = 5'd7;
    #2; vectors++;
    if (rs1_data_o !== 64'h42) begin
      miscompares++; $display("FAIL bypass_landed got %h want %h", rs1_data_o, 64'h42);
    end
  endtask

  task automatic test_raw_stall();
    issue_to(5'd3);
    idle(); rs1_used_i = 1; rs1_idx_i = 5'd3;
    #2; vectors++;
    if (issue_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL raw_stall got %b want 0", issue_ready_o);
    end
    vectors++;
    if (busy_vec_o[3] !== 1'b1) begin
      miscompares++; $display("FAIL raw_busy3 got %b want 1", busy_vec_o[3]);
    end
    tick();
    wb_wren_i = 1; wb_rd_idx_i = 5'd3; wb_rd_data_i = 64'h0123_4567_89AB_CDEF;
    #2; vectors++;
    if (issue_ready_o !== 1'b1 || rs1_data_o !== 64'h0123_4567_89AB_CDEF) begin
      miscompares++;
      $display("FAIL raw_release got rdy %b data %h want 1 %h", issue_ready_o, rs1_data_o,
               64'h0123_4567_89AB_CDEF);
    end
    tick();
    idle(); #2; vectors++;
    if (busy_vec_o[3] !== 1'b0) begin
      miscompares++; $display("FAIL raw_busy3_clear got %b want 0", busy_vec_o[3]);
    end
  endtask

  task automatic test_counter_full();
    for (int k = 0; k < 3; k++) issue_to(5'd9);
    idle(); issue_wren_i = 1; issue_rd_idx_i = 5'd9;
    #2; vectors++;
    if (issue_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL full_stall got %b want 0", issue_ready_o);
    end
    wb_wren_i = 1; wb_rd_idx_i = 5'd9; wb_rd_data_i = 64'h99;
    #1; vectors++;
    if (issue_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL full_wb_release got %b want 1", issue_ready_o);
    end
    issue_valid_i = 1;
    tick();
    idle(); issue_wren_i = 1; issue_rd_idx_i = 5'd9;
    #2; vectors++;
    if (issue_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL full_still got %b want 0", issue_ready_o);
    end
    squash_valid_i = 1; squash_rd_idx_i = 5'd9;
    #1; vectors++;
    if (issue_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL full_squash_release got %b want 1", issue_ready_o);
    end
    issue_wren_i = 0;
    tick();
    for (int k = 0; k < 2; k++) begin
      idle(); wb_wren_i = 1; wb_rd_idx_i = 5'd9; wb_rd_data_i = 64'(k + 100);
      tick();
    end
    idle(); #2; vectors++;
    if (busy_vec_o !== m_busy() || busy_vec_o[9] !== 1'b0) begin
      miscompares++; $display("FAIL full_drain got %h want %h", busy_vec_o, m_busy());
    end
  endtask

  task automatic test_squash();
    issue_to(5'd4);
    issue_to(5'd4);
    idle(); squash_valid_i = 1; squash_rd_idx_i = 5'd4;
    issue_valid_i = 1; issue_wren_i = 1; issue_rd_idx_i = 5'd4;
    wb_wren_i = 1; wb_rd_idx_i = 5'd4; wb_rd_data_i = 64'hA5A5;
    #2; vectors++;
    if (issue_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL sq_triple_ready got %b want 1", issue_ready_o);
    end
    tick();
    idle(); rs1_used_i = 1; rs1_idx_i = 5'd4;
    #2; vectors++;
    if (issue_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL sq_cnt1_stall got %b want 0", issue_ready_o);
    end
    wb_wren_i = 1; wb_rd_idx_i = 5'd4; wb_rd_data_i = 64'h5A5A;
    #1; vectors++;
    if (issue_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL sq_cnt1_release got %b want 1", issue_ready_o);
    end
    tick();
    idle(); squash_valid_i = 1; squash_rd_idx_i = 5'd4;
    tick();
    idle(); #2; vectors++;
    if (busy_vec_o[4] !== 1'b0) begin
      miscompares++; $display("FAIL sq_saturate got %b want 0", busy_vec_o[4]);
    end
    issue_to(5'd4);
    idle(); rs1_used_i = 1; rs1_idx_i = 5'd4; wb_wren_i = 1; wb_rd_idx_i = 5'd4; wb_rd_data_i = 64'h7;
    #2; vectors++;
    if (issue_ready_o !== 1'b1 || busy_vec_o[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL sq_reuse got rdy %b busy %b want 1 1", issue_ready_o, busy_vec_o[4]);
    end
    tick();
  endtask

  task automatic test_random();
    int  r;
    int  start;
    bit  found;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      idle();
      found = 0;
      if ($urandom_range(0, 2) != 0) begin
        start = $urandom_range(0, 31);
        for (int k = 0; k < 32 && !found; k++) begin
          r = (start + k) % 32;
          if (r != 0 && m_cnt[r] > 0) found = 1;
        end
        if (found) begin wb_wren_i = 1; wb_rd_idx_i = 5'(r); end
      end
      if (!found && $urandom_range(0, 15) == 0) wb_wren_i = 1;
      wb_rd_data_i = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        found = 0;
        start = $urandom_range(0, 31);
        for (int k = 0; k < 32 && !found; k++) begin
          r = (start + k) % 32;
          if (r != 0 && m_cnt[r] - ((wb_wren_i && wb_rd_idx_i == 5'(r)) ? 1 : 0) > 0) found = 1;
        end
        if (found) begin squash_valid_i = 1; squash_rd_idx_i = 5'(r); end
      end
      rs1_idx_i = 5'($urandom_range(0, 9)); rs2_idx_i = 5'($urandom_range(0, 9));
      rs1_used_i = 1'($urandom_range(0, 1)); rs2_used_i = 1'($urandom_range(0, 1));
      issue_wren_i = 1'($urandom_range(0, 1)); issue_rd_idx_i = 5'($urandom_range(0, 9));
      issue_valid_i = ($urandom_range(0, 1) == 1) && m_ready();
      #2;
      vectors++;
      if (rs1_data_o !== m_read(rs1_idx_i)) begin
        miscompares++; $display("FAIL rnd_rs1 cyc %0d got %h want %h", cyc, rs1_data_o, m_read(rs1_idx_i));
      end
      vectors++;
      if (rs2_data_o !== m_read(rs2_idx_i)) begin
        miscompares++; $display("FAIL rnd_rs2 cyc %0d got %h want %h", cyc, rs2_data_o, m_read(rs2_idx_i));
      end
      vectors++;
      if (issue_ready_o !== m_ready()) begin
        miscompares++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, issue_ready_o, m_ready());
      end
      vectors++;
      if (busy_vec_o !== m_busy()) begin
        miscompares++; $display("FAIL rnd_busy cyc %0d got %h want %h", cyc, busy_vec_o, m_busy());
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    test_reset(1'b0);
    test_write_read();
    test_bypass();
    test_raw_stall();
    test_counter_full();
    test_squash();
    test_random();
    test_reset(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
